uart_vertex_frame_ctrl: RTL and testbench

// - Byte-level frame controller between the UART RX/TX byte modules and the MPU6050 gyro reader.
// - Loads a vertex table from 0xAA-headed frames into local RAM.
// - On a 0xBB request, streams a gyro snapshot followed by the stored vertex table.
// - Generalises the fixed 3x32-bit loader to any coordinate count and width, and any gyro channel count.
// - Adds a valid/ready TX handshake, frame validation and an error report.

---
 rtl/uart_vertex_frame_ctrl_pkg.sv | 22 ++
 rtl/uart_vertex_frame_ctrl_if.sv | 27 ++
 rtl/vertex_byte_ram.sv | 24 ++
 rtl/uart_vertex_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_vertex_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_vertex_frame_ctrl_pkg.sv
// Shared types and helpers for the UART vertex frame controller.
// Frame states, default header bytes and the frame length helper live here.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_COUNT,
        RX_VERT,
        RX_CSUM,
        TX_GYRO,
        TX_VERT
    } frame_state_t;

    localparam logic [7:0] HDR_LOAD_BYTE = 8'hAA;
    localparam logic [7:0] HDR_REQ_BYTE  = 8'hBB;

    // Number of payload bytes carried by n vertices.
    function automatic int frame_bytes(input int n, input int coords, input int cbytes);
        return n * coords * cbytes;
    endfunction

endpackage

// File: rtl/uart_vertex_frame_ctrl_if.sv
// Byte-stream bundle between the UART RX/TX byte modules and the frame controller.
// The controller uses the slave view; the UART side (or a bench) uses the master view.
interface uart_vertex_frame_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/vertex_byte_ram.sv
// Byte-wide vertex storage: one write port, one synchronous read port, no reset.
module vertex_byte_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Write the incoming byte and register the read data one cycle after the address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/uart_vertex_frame_ctrl.sv
// Frame controller: loads vertex tables from 0xAA frames and answers 0xBB requests
// with a gyro snapshot followed by the stored vertex table.
// Optional feature macro: FRAME_CSUM_EN (frame checksum on load, trailing checksum on dump).
module uart_vertex_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_VERTICES = 100,
    parameter int         COORDS       = 3,
    parameter int         COORD_BYTES  = 4,
    parameter int         GYRO_CH      = 3,
    parameter logic [7:0] HDR_LOAD     = HDR_LOAD_BYTE,
    parameter logic [7:0] HDR_REQ      = HDR_REQ_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_vertex_frame_ctrl_if.slave  io_bus,
    input  logic [16*GYRO_CH-1:0]    i_gyro_data,
    output logic [7:0]               o_vertex_count,
    output logic                     o_busy,
    output logic                     o_frame_err,
    output logic                     o_rx_overrun
);

    localparam int DEPTH      = MAX_VERTICES * COORDS * COORD_BYTES;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = AW + 1;
    localparam int GYRO_BYTES = 2 * GYRO_CH;
    localparam int GW         = $clog2(GYRO_BYTES + 1);

    frame_state_t          r_state;
    frame_state_t          w_nextState;
    logic [7:0]            r_pendCount;
    logic [7:0]            r_vertexCount;
    logic [7:0]            r_txData;
    logic                  r_txValid;
    logic                  r_frameErr;
    logic                  r_rxOverrun;
    logic [CW-1:0]         r_wPtr;
    logic [CW-1:0]         r_vIdx;
    logic [CW-1:0]         w_vIdxNext;
    logic [CW-1:0]         w_loadTotal;
    logic [CW-1:0]         w_dumpTotal;
    logic [CW-1:0]         w_txLast;
    logic [GW-1:0]         r_gIdx;
    logic [16*GYRO_CH-1:0] r_gyroSnap;
    logic [7:0]            w_ramQ;
    logic [7:0]            w_gyroByte;
    logic [7:0]            w_presentData;
    logic                  w_accept;
    logic                  w_present;
    logic                  w_snap;
    logic                  w_loadStart;
    logic                  w_ramWe;
    logic                  w_commit;
    logic                  w_clearCount;
    logic                  w_frameErr;
    logic                  w_overrun;
`ifdef FRAME_CSUM_EN
    logic [7:0]            r_rxSum;
    logic [7:0]            r_txSum;
`endif

    assign w_accept    = r_txValid && io_bus.tx_ready;
    assign w_present   = (r_state == TX_GYRO) || (r_state == TX_VERT);
    assign w_loadTotal = CW'(frame_bytes(int'(r_pendCount), COORDS, COORD_BYTES));
    assign w_dumpTotal = CW'(frame_bytes(int'(r_vertexCount), COORDS, COORD_BYTES));
`ifdef FRAME_CSUM_EN
    assign w_txLast    = w_dumpTotal;
`else
    assign w_txLast    = w_dumpTotal - CW'(1);
`endif

    assign io_bus.tx_data  = r_txData;
    assign io_bus.tx_valid = r_txValid;
    assign o_vertex_count  = r_vertexCount;
    assign o_busy          = (r_state != IDLE);
    assign o_frame_err     = r_frameErr;
    assign o_rx_overrun    = r_rxOverrun;

    vertex_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_waddr (r_wPtr[AW-1:0]),
        .i_wdata (io_bus.rx_data),
        .i_raddr (w_vIdxNext[AW-1:0]),
        .o_rdata (w_ramQ)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the one-cycle control strobes for the datapath.
    always_comb begin
        w_nextState  = r_state;
        w_snap       = 1'b0;
        w_loadStart  = 1'b0;
        w_ramWe      = 1'b0;
        w_commit     = 1'b0;
        w_clearCount = 1'b0;
        w_frameErr   = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data == HDR_LOAD) begin
                        w_nextState = RX_COUNT;
                    end else if (io_bus.rx_data == HDR_REQ) begin
                        w_nextState = TX_GYRO;
                        w_snap      = 1'b1;
                    end
                end
            end
            RX_COUNT: begin
                if (io_bus.rx_valid) begin
                    if (io_bus.rx_data != 8'd0 && int'(io_bus.rx_data) <= MAX_VERTICES) begin
                        w_loadStart = 1'b1;
                        w_nextState = RX_VERT;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            RX_VERT: begin
                if (io_bus.rx_valid) begin
                    w_ramWe = 1'b1;
                    if (r_wPtr == w_loadTotal - CW'(1)) begin
`ifdef FRAME_CSUM_EN
                        w_nextState = RX_CSUM;
`else
                        w_commit    = 1'b1;
                        w_nextState = IDLE;
`endif
                    end
                end
            end
            RX_CSUM: begin
`ifdef FRAME_CSUM_EN
                if (io_bus.rx_valid) begin
                    w_nextState = IDLE;
                    if (r_rxSum + io_bus.rx_data == 8'd0) begin
                        w_commit = 1'b1;
                    end else begin
                        w_frameErr   = 1'b1;
                        w_clearCount = 1'b1;
                    end
                end
`else
                w_nextState = IDLE;
`endif
            end
            TX_GYRO: begin
                w_overrun = io_bus.rx_valid;
                if (w_accept && int'(r_gIdx) == GYRO_BYTES - 1) begin
`ifdef FRAME_CSUM_EN
                    w_nextState = TX_VERT;
`else
                    w_nextState = (r_vertexCount == 8'd0) ? IDLE : TX_VERT;
`endif
                end
            end
            TX_VERT: begin
                w_overrun = io_bus.rx_valid;
                if (w_accept && r_vIdx == w_txLast) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // RAM read address runs one step ahead of the dump pointer so the byte is ready when presented.
    always_comb begin
        w_vIdxNext = '0;
        if (r_state == TX_VERT) begin
            w_vIdxNext = w_accept ? r_vIdx + CW'(1) : r_vIdx;
        end
    end

    // Pick the snapshot byte for the current gyro index: channel 0 first, high byte first.
    always_comb begin
        w_gyroByte = 8'h00;
        for (int c = 0; c < GYRO_CH; c++) begin
            if (int'(r_gIdx) == 2 * c) begin
                w_gyroByte = r_gyroSnap[16*c+8 +: 8];
            end
            if (int'(r_gIdx) == 2 * c + 1) begin
                w_gyroByte = r_gyroSnap[16*c +: 8];
            end
        end
    end

    // Choose the next byte to present: gyro, vertex RAM, or the trailing checksum.
    always_comb begin
        w_presentData = w_gyroByte;
        if (r_state == TX_VERT) begin
            w_presentData = w_ramQ;
`ifdef FRAME_CSUM_EN
            if (r_vIdx == w_dumpTotal) begin
                w_presentData = ~r_txSum + 8'd1;
            end
`endif
        end
    end

    // Datapath: load pointers, vertex count, gyro snapshot, TX handshake and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendCount   <= 8'd0;
            r_vertexCount <= 8'd0;
            r_txData      <= 8'd0;
            r_txValid     <= 1'b0;
            r_frameErr    <= 1'b0;
            r_rxOverrun   <= 1'b0;
            r_wPtr        <= '0;
            r_vIdx        <= '0;
            r_gIdx        <= '0;
            r_gyroSnap    <= '0;
`ifdef FRAME_CSUM_EN
            r_rxSum       <= 8'd0;
            r_txSum       <= 8'd0;
`endif
        end else begin
            r_frameErr  <= w_frameErr;
            r_rxOverrun <= w_overrun;
            r_vIdx      <= w_vIdxNext;
            if (w_snap) begin
                r_gyroSnap <= i_gyro_data;
`ifdef FRAME_CSUM_EN
                r_txSum    <= 8'd0;
`endif
            end
            if (w_loadStart) begin
                r_pendCount <= io_bus.rx_data;
                r_wPtr      <= '0;
`ifdef FRAME_CSUM_EN
                r_rxSum     <= io_bus.rx_data;
`endif
            end
            if (w_ramWe) begin
                r_wPtr <= r_wPtr + CW'(1);
`ifdef FRAME_CSUM_EN
                r_rxSum <= r_rxSum + io_bus.rx_data;
`endif
            end
            if (w_commit) begin
                r_vertexCount <= r_pendCount;
            end
            if (w_clearCount) begin
                r_vertexCount <= 8'd0;
            end
            if (r_state != TX_GYRO) begin
                r_gIdx <= '0;
            end else if (w_accept) begin
                r_gIdx <= r_gIdx + GW'(1);
            end
            if (w_accept) begin
                r_txValid <= 1'b0;
`ifdef FRAME_CSUM_EN
                r_txSum   <= r_txSum + r_txData;
`endif
            end else if (!r_txValid && w_present) begin
                r_txValid <= 1'b1;
                r_txData  <= w_presentData;
            end
        end
    end

endmodule

// File: tb/tb_uart_vertex_frame_ctrl.sv
// Directed bench for uart_vertex_frame_ctrl (default parameters: 100 vertices, 3x4-byte coords, 3 gyro channels).
// Honours FRAME_CSUM_EN so the same bench covers both builds.
module tb_uart_vertex_frame_ctrl;

    localparam int DUMP_LIMIT = 4000;

    logic        clk;
    logic        rst;
    logic [47:0] gyroData;
    logic [7:0]  vertexCount;
    logic        dutBusy;
    logic        dutFrameErr;
    logic        dutOverrun;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] expBytes[$];
    logic [7:0] rxBytes[$];

    uart_vertex_frame_ctrl_if bus();

    uart_vertex_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .io_bus         (bus),
        .i_gyro_data    (gyroData),
        .o_vertex_count (vertexCount),
        .o_busy         (dutBusy),
        .o_frame_err    (dutFrameErr),
        .o_rx_overrun   (dutOverrun)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle rx strobe; returns just after the edge that captured the byte.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Load frame of n vertices with payload base, base+1, ...
    task automatic loadFrame(input int n, input logic [7:0] base);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'(n);
        applyStimulus(8'hAA);
        applyStimulus(8'(n));
        for (int i = 0; i < n * 12; i++) begin
            b = base + 8'(i);
            sum = sum + b;
            applyStimulus(b);
        end
`ifdef FRAME_CSUM_EN
        applyStimulus(~sum + 8'd1);
`endif
    endtask

    // Expected dump: gyro channels high byte first, then vertex bytes, then optional checksum.
    task automatic buildExpected(input logic [47:0] gyro, input int nVert, input logic [7:0] base);
        logic [7:0] sum;
        logic [7:0] b;
        expBytes.delete();
        sum = 8'd0;
        for (int c = 0; c < 3; c++) begin
            b = gyro[16*c+8 +: 8];
            expBytes.push_back(b);
            sum = sum + b;
            b = gyro[16*c +: 8];
            expBytes.push_back(b);
            sum = sum + b;
        end
        for (int i = 0; i < nVert * 12; i++) begin
            b = base + 8'(i);
            expBytes.push_back(b);
            sum = sum + b;
        end
`ifdef FRAME_CSUM_EN
        expBytes.push_back(~sum + 8'd1);
`endif
    endtask

    // Collect a dump; optionally stall tx_ready before byte stallAfter and inject an rx byte at cycle overrunAt.
    task automatic receiveDump(input int stallAfter, input int stallCycles, input int overrunAt);
        int cycles;
        bit stallDone;
        bit overrunCheck;
        cycles       = 0;
        stallDone    = 1'b0;
        overrunCheck = 1'b0;
        rxBytes.delete();
        bus.tx_ready = 1'b1;
        while ((dutBusy || bus.tx_valid) && cycles < DUMP_LIMIT) begin
            if (bus.tx_valid && !stallDone && rxBytes.size() == stallAfter) begin
                bus.tx_ready = 1'b0;
                for (int s = 0; s < stallCycles; s++) begin
                    @(posedge clk);
                    #1;
                    cycles++;
                    checkOutput("stallValid", 32'(bus.tx_valid), 1);
                    checkOutput("stallData", 32'(bus.tx_data), 32'(expBytes[stallAfter]));
                end
                bus.tx_ready = 1'b1;
                stallDone = 1'b1;
            end
            if (cycles == overrunAt) begin
                bus.rx_data  = 8'hAA;
                bus.rx_valid = 1'b1;
                overrunCheck = 1'b1;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                rxBytes.push_back(bus.tx_data);
            end
            @(posedge clk);
            #1;
            cycles++;
            if (overrunCheck) begin
                bus.rx_valid = 1'b0;
                checkOutput("rxOverrun", 32'(dutOverrun), 1);
                overrunCheck = 1'b0;
            end
        end
        checkOutput("dumpFinished", 32'(cycles < DUMP_LIMIT), 1);
    endtask

    task automatic compareDump(input string tag);
        int n;
        checkOutput({tag, "_len"}, 32'(rxBytes.size()), 32'(expBytes.size()));
        n = (rxBytes.size() < expBytes.size()) ? rxBytes.size() : expBytes.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rxBytes[i]), 32'(expBytes[i]));
        end
    endtask

    // Directed sequence covering reset, load, dump, validation, back-pressure, overrun and mid-dump reset.
    initial begin
        rst          = 1'b1;
        gyroData     = 48'h0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then a request with no table stored.
        checkOutput("rstTxValid", 32'(bus.tx_valid), 0);
        checkOutput("rstTxData", 32'(bus.tx_data), 0);
        checkOutput("rstCount", 32'(vertexCount), 0);
        checkOutput("rstBusy", 32'(dutBusy), 0);
        gyroData = 48'h0F0F_ABCD_1234;
        applyStimulus(8'hBB);
        checkOutput("reqBusy", 32'(dutBusy), 1);
        buildExpected(48'h0F0F_ABCD_1234, 0, 8'h00);
        receiveDump(-1, 0, -1);
        compareDump("emptyDump");
        checkOutput("emptyCount", 32'(vertexCount), 0);

        // Single vertex load followed by a dump; gyro changes after the request must not show up.
        loadFrame(1, 8'h01);
        checkOutput("load1Count", 32'(vertexCount), 1);
        checkOutput("load1Busy", 32'(dutBusy), 0);
        gyroData = 48'h0F0F_ABCD_1234;
        applyStimulus(8'hBB);
        gyroData = 48'hFFFF_FFFF_FFFF;
        buildExpected(48'h0F0F_ABCD_1234, 1, 8'h01);
        checkOutput("hand_b0", 32'(expBytes[0]), 32'h12);
        receiveDump(-1, 0, -1);
        compareDump("dump1");

        // Count of zero and count above the maximum are rejected.
        applyStimulus(8'hAA);
        applyStimulus(8'h00);
        checkOutput("cnt0Err", 32'(dutFrameErr), 1);
        checkOutput("cnt0Busy", 32'(dutBusy), 0);
        @(posedge clk);
        #1;
        checkOutput("cnt0ErrPulse", 32'(dutFrameErr), 0);
        applyStimulus(8'hAA);
        applyStimulus(8'h65);
        checkOutput("cnt101Err", 32'(dutFrameErr), 1);
        checkOutput("cnt101Busy", 32'(dutBusy), 0);
        @(posedge clk);
        #1;
        checkOutput("cnt101ErrPulse", 32'(dutFrameErr), 0);
        checkOutput("cntKept", 32'(vertexCount), 1);

        // Two vertex load, dump with five stalled cycles in the vertex stream.
        loadFrame(2, 8'h20);
        checkOutput("load2Count", 32'(vertexCount), 2);
        gyroData = 48'h5566_3344_1122;
        applyStimulus(8'hBB);
        buildExpected(48'h5566_3344_1122, 2, 8'h20);
        receiveDump(11, 5, -1);
        compareDump("stallDump");

        // A byte arriving mid-dump is dropped and flagged; the dump is unaffected.
        gyroData = 48'h0102_0304_0506;
        applyStimulus(8'hBB);
        buildExpected(48'h0102_0304_0506, 2, 8'h20);
        receiveDump(-1, 0, 3);
        compareDump("overrunDump");
        checkOutput("overrunCount", 32'(vertexCount), 2);
        checkOutput("overrunIdle", 32'(dutBusy), 0);

        // Reset while streaming vertex bytes, then a request sends gyro bytes only.
        gyroData = 48'h0F0F_ABCD_1234;
        applyStimulus(8'hBB);
        bus.tx_ready = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        checkOutput("preRstValid", 32'(bus.tx_valid), 1);
        checkOutput("preRstData", 32'(bus.tx_data), 32'h23);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(bus.tx_valid), 0);
        checkOutput("midRstBusy", 32'(dutBusy), 0);
        checkOutput("midRstCount", 32'(vertexCount), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'hBB);
        buildExpected(48'h0F0F_ABCD_1234, 0, 8'h00);
        receiveDump(-1, 0, -1);
        compareDump("postRstDump");

`ifdef FRAME_CSUM_EN
        // Checksum accepted, then the same frame with a wrong checksum clears the table.
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        for (int i = 1; i <= 12; i++) applyStimulus(8'(i));
        applyStimulus(8'hB1);
        checkOutput("csumGoodCount", 32'(vertexCount), 1);
        checkOutput("csumGoodErr", 32'(dutFrameErr), 0);
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        for (int i = 1; i <= 12; i++) applyStimulus(8'(i));
        applyStimulus(8'hB2);
        checkOutput("csumBadErr", 32'(dutFrameErr), 1);
        checkOutput("csumBadCount", 32'(vertexCount), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
